// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared CPU front-end definitions: reset vector, bus width helpers and the
// redirect-source numbering used by the fetch controller.
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

  // Lower value means higher priority when several sources redirect together.
  typedef enum logic [1:0] {
    REDIR_EXCEPTION = 2'd0,
    REDIR_BRANCH    = 2'd1,
    REDIR_PREDICT   = 2'd2
  } redir_src_e;

  function automatic int bus_data_bits(input int fetch_bytes);
    return 8 * fetch_bytes;
  endfunction

  function automatic int offset_bits(input int fetch_bytes);
    return $clog2(fetch_bytes);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_fifo.sv
// Small circular FIFO (pointers plus count) with the head word visible
// combinationally; the head reads as zero while empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign do_pop    = pop && !empty;
  // A pop frees the slot the push lands in, so a full FIFO may push and pop together.
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch PC controller: credit-limited requests on an SRAM-like
// bus, prioritised redirects, stale-response dropping and an output buffer.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          FETCH_BYTES = 4,
  parameter int          MAX_OUTST   = 2,
  parameter int          NUM_REDIR   = 2,
  localparam int         DATA_W      = bus_data_bits(FETCH_BYTES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REDIR-1:0]   redir_valid,
  input  logic [32*NUM_REDIR-1:0] redir_pc,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [DATA_W-1:0]      inst_rdata,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready
);

  localparam int          CNT_W      = $clog2(MAX_OUTST + 1);
  localparam int          OFS_W      = offset_bits(FETCH_BYTES);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFS_W) - 32'd1);

  logic [31:0]       fpc_reg, fpc_next;
  logic              pend_reg, pend_next;
  logic [31:0]       pend_pc_reg, pend_pc_next;
  logic [CNT_W-1:0]  stale_reg, stale_next;

  logic [31:0]       src_target [NUM_REDIR];
  logic              redir_any;
  logic [31:0]       redir_target;

  logic              accept, ob_push;
  logic [31:0]       if_head;
  logic              if_empty, if_full, ob_empty, ob_full;
  logic [CNT_W-1:0]  if_count, ob_count;
  logic [CNT_W:0]    total_count;
  logic [DATA_W+31:0] ob_head;

  for (genvar gi = 0; gi < NUM_REDIR; gi++) begin : g_src
    assign src_target[gi] = redir_pc[32*gi +: 32] & ALIGN_MASK;
  end

  // Scan from the lowest priority upward so the lowest asserted index wins.
  always_comb begin
    redir_any    = |redir_valid;
    redir_target = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) redir_target = src_target[i];
    end
  end

  // Credits count stale in-flight entries too: their responses still arrive.
  assign total_count = {1'b0, if_count} + {1'b0, ob_count};
  assign inst_req    = (total_count < (CNT_W + 1)'(MAX_OUTST));
  assign inst_addr   = fpc_reg;
  assign accept      = inst_req && inst_addr_ok;
  assign ob_push     = inst_data_ok && !if_empty && !redir_any && (stale_reg == '0);

  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_inflight (
    .clock     (clock),
    .reset     (reset),
    .flush     (1'b0),
    .push      (accept),
    .push_data (fpc_reg),
    .pop       (inst_data_ok),
    .head_data (if_head),
    .empty     (if_empty),
    .full      (if_full),
    .count     (if_count)
  );

  fetch_fifo #(.WIDTH(DATA_W + 32), .DEPTH(MAX_OUTST)) u_outbuf (
    .clock     (clock),
    .reset     (reset),
    .flush     (redir_any),
    .push      (ob_push),
    .push_data ({if_head, inst_rdata}),
    .pop       (out_ready),
    .head_data (ob_head),
    .empty     (ob_empty),
    .full      (ob_full),
    .count     (ob_count)
  );

  assign out_valid = !ob_empty;
  assign out_pc    = ob_head[DATA_W +: 32];
  assign out_data  = ob_head[DATA_W-1:0];

  // Stale entries are always the oldest ones, so a count replaces per-entry marks.
  always_comb begin
    fpc_next     = fpc_reg;
    pend_next    = pend_reg;
    pend_pc_next = pend_pc_reg;
    stale_next   = stale_reg;
    if (inst_data_ok && (stale_reg != '0)) stale_next = stale_reg - CNT_W'(1);
    if (accept && pend_reg)                stale_next = stale_next + CNT_W'(1);
    if (accept) begin
      fpc_next  = pend_reg ? pend_pc_reg : fpc_reg + 32'(FETCH_BYTES);
      pend_next = 1'b0;
    end
    if (redir_any) begin
      stale_next = if_count + CNT_W'(accept) - CNT_W'(inst_data_ok);
      if (inst_req && !inst_addr_ok) begin
        // The offered request must stay stable; retarget once it is taken.
        pend_next    = 1'b1;
        pend_pc_next = redir_target;
      end else begin
        fpc_next  = redir_target;
        pend_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fpc_reg     <= RESET_PC;
      pend_reg    <= 1'b0;
      pend_pc_reg <= '0;
      stale_reg   <= '0;
    end else begin
      fpc_reg     <= fpc_next;
      pend_reg    <= pend_next;
      pend_pc_reg <= pend_pc_next;
      stale_reg   <= stale_next;
    end
  end

  a_no_orphan_resp: assert property (@(posedge clock) disable iff (reset)
    !(inst_data_ok && if_empty));
  a_no_inflight_ovf: assert property (@(posedge clock) disable iff (reset)
    !(accept && if_full && !inst_data_ok));
  a_no_outbuf_ovf: assert property (@(posedge clock) disable iff (reset)
    !(ob_push && ob_full && !out_ready));

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed stimulus queues expected
// bundles, a negedge monitor/bus responder pops and compares them.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  localparam logic [31:0] KEY = 32'h5a5a_c3c3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  redir_valid = '0;
  logic [63:0] redir_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;

  always #5 clock = ~clock;

  pc_fetch_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_data     (out_data),
    .out_ready    (out_ready)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] bus_q [$];
  int          grant_total = 0;
  int          accepts = 0;
  logic        resp_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor and bus model: decisions taken at negedge take effect at the next posedge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus_q.delete();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_out: got pc %h, no bundle expected", out_pc);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e);
            check("out_data", out_data, e ^ KEY);
          end
        end
        if (!resp_hold && bus_q.size() > 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = bus_q.pop_front() ^ KEY;
        end else begin
          inst_data_ok = 1'b0;
        end
        if (accepts < grant_total && inst_req) begin
          inst_addr_ok = 1'b1;
          bus_q.push_back(inst_addr);
          accepts++;
        end else begin
          inst_addr_ok = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || accepts != grant_total || bus_q.size() != 0) && cyc < 200) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc >= 200) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d bundles still pending, required 0 within 200 cycles", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
    check({name, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_accepts(input int target);
    int cyc = 0;
    while (accepts < target && cyc < 100) begin
      tick();
      cyc++;
    end
    check("accept_wait", 32'(accepts), 32'(target));
  endtask

  task automatic redirect(input logic [1:0] v, input logic [31:0] pc1, input logic [31:0] pc0);
    redir_valid = v;
    redir_pc    = {pc1, pc0};
    tick();
    redir_valid = '0;
  endtask

  initial begin
    int base;
    tick(3);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    check("rel_inst_req", 32'(inst_req), 32'd1);
    check("rel_inst_addr", inst_addr, 32'hbfc00000);

    // Sequential fetch from the reset vector.
    out_ready = 1'b1;
    exp_q.push_back(32'hbfc00000);
    exp_q.push_back(32'hbfc00004);
    exp_q.push_back(32'hbfc00008);
    grant_total += 3;
    drain("seq");

    // Consumer stalled: credits cap outstanding fetches at two.
    out_ready = 1'b0;
    base = accepts;
    grant_total += 10;
    tick(10);
    check("credit_accepts", 32'(accepts - base), 32'd2);
    check("credit_req", 32'(inst_req), 32'd0);
    check("credit_out_pc", out_pc, 32'hbfc0000c);
    grant_total = accepts;
    exp_q.push_back(32'hbfc0000c);
    exp_q.push_back(32'hbfc00010);
    out_ready = 1'b1;
    drain("credit");

    // Redirect with two requests in flight: both responses are dropped.
    resp_hold = 1'b1;
    base = accepts;
    grant_total += 2;
    wait_accepts(base + 2);
    redirect(2'b10, 32'h80001000, 32'h0);
    check("redir_addr", inst_addr, 32'h80001000);
    check("redir_req_busy", 32'(inst_req), 32'd0);
    resp_hold = 1'b0;
    tick(4);
    check("stale_dropped", 32'(out_valid), 32'd0);
    exp_q.push_back(32'h80001000);
    grant_total += 1;
    drain("redir");

    // Both sources at once: source 0 wins; request pending so retarget is deferred.
    redirect(2'b11, 32'h80002000, 32'hbfc00380);
    check("prio_pend_addr", inst_addr, 32'h80001004);
    exp_q.push_back(32'hbfc00380);
    grant_total += 2;
    drain("prio");
    check("prio_next_addr", inst_addr, 32'hbfc00384);

    // Redirect (misaligned target) while the request is held for three cycles.
    redirect(2'b01, 32'h0, 32'h80003003);
    for (int i = 0; i < 3; i++) begin
      check("hold_addr", inst_addr, 32'hbfc00384);
      check("hold_req", 32'(inst_req), 32'd1);
      tick();
    end
    exp_q.push_back(32'h80003000);
    grant_total += 2;
    drain("hold");

    // PC wraps modulo 2^32.
    redirect(2'b01, 32'h0, 32'hfffffffc);
    exp_q.push_back(32'hfffffffc);
    exp_q.push_back(32'h00000000);
    grant_total += 3;
    drain("wrap");
    check("wrap_addr", inst_addr, 32'h00000004);

    // Reset with buffered bundles discards everything.
    out_ready = 1'b0;
    grant_total += 2;
    tick(6);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_pc", out_pc, 32'h00000004);
    reset = 1'b1;
    tick(2);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pc", out_pc, 32'd0);
    check("mid_rst_addr", inst_addr, 32'hbfc00000);
    reset = 1'b0;
    check("post_rst_req", 32'(inst_req), 32'd1);
    out_ready = 1'b1;
    exp_q.push_back(32'hbfc00000);
    grant_total += 1;
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hbfc00000: first fetch address after reset.
REQ-002 SHALL have parameter FETCH_BYTES, default 4: bytes per fetch (4 or 8) and PC increment.
REQ-003 SHALL have parameter MAX_OUTST, default 2: maximum in-flight plus buffered fetches (1..4).
REQ-004 SHALL have parameter NUM_REDIR, default 2: redirect sources; index 0 has highest priority.
REQ-005 SHALL have port clock  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port redir_valid  in  NUM_REDIR  per-source redirect request (exception, branch, ...).
REQ-008 SHALL have port redir_pc  in  32*NUM_REDIR  redirect targets; source i occupies bits [32i+31:32i].
REQ-009 SHALL have port inst_req  out  1  fetch request to instruction SRAM-like bus.
REQ-010 SHALL have port inst_addr  out  32  fetch address.
REQ-011 SHALL have port inst_addr_ok  in  1  request accepted this cycle.
REQ-012 SHALL have port inst_data_ok  in  1  response valid this cycle, in request order.
REQ-013 SHALL have port inst_rdata  in  8*FETCH_BYTES  response data.
REQ-014 SHALL have port out_valid  out  1  fetched bundle available.
REQ-015 SHALL have port out_pc  out  32  address of the bundle.
REQ-016 SHALL have port out_data  out  8*FETCH_BYTES  bundle data.
REQ-017 SHALL have port out_ready  in  1  consumer accepts bundle (pops when out_valid and out_ready).

Function
REQ-018 SHALL hold a fetch PC register (fpc); inst_addr SHALL equal fpc.
REQ-019 SHALL assert inst_req when in-flight + buffered count < MAX_OUTST; once asserted, inst_req and inst_addr SHALL stay stable until inst_addr_ok.
REQ-020 On inst_addr_ok with no redirect, SHALL push fpc into the in-flight queue and set fpc <= fpc+FETCH_BYTES, wrapping modulo 2^32.
REQ-021 On any redir_valid, SHALL select the lowest-index asserted source and set fpc <= its target with low log2(FETCH_BYTES) bits cleared, next cycle.
REQ-022 A redirect SHALL mark every in-flight entry stale, including one accepted by inst_addr_ok in the same cycle, and SHALL flush the output buffer.
REQ-023 A redirect while inst_req is pending without inst_addr_ok SHALL keep the current request stable until accepted; that request SHALL be stale; fpc SHALL update to the target after acceptance.
REQ-024 On inst_data_ok, SHALL pop the oldest in-flight entry; a stale entry's data SHALL be discarded, otherwise {pc, data} SHALL be pushed into the output buffer.
REQ-025 inst_data_ok coinciding with a redirect SHALL discard that response.
REQ-026 The output buffer SHALL present the oldest entry on out_pc/out_data with zero added latency (response to out_valid in the next cycle).
REQ-027 The credit rule in REQ-019 SHALL guarantee no buffer overflow; inst_data_ok with an empty in-flight queue is illegal and SHALL be flagged by an assertion.
REQ-028 Simultaneous push and pop on a full buffer SHALL be allowed.

Reset
REQ-029 Reset SHALL set fpc=RESET_PC, inst_req=1 in the first cycle after deassertion, out_valid=0, out_pc=0, out_data=0, and all queues empty with no stale marks.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered fetches; the bus side SHALL be reset by the same reset.

Structure
REQ-031 RESET_PC default, bus data width helpers and a redirect-source index enum SHALL reside in the shared CPU defines package.
REQ-032 In-flight and output queues SHALL use one sub-module, fetch_fifo (parametrised width and depth, circular pointers plus count).

Verification
REQ-033 Reset release, addr_ok every cycle, data_ok one cycle later -> out_pc sequence bfc00000, bfc00004, bfc00008.
REQ-034 out_ready=0 with MAX_OUTST=2 -> exactly two requests accepted, then inst_req=0 until a pop.
REQ-035 Two requests in flight and redir_valid[1]=1 to 80001000 -> both responses dropped; next out_pc=80001000.
REQ-036 redir_valid=2'b11 with targets bfc00380/80002000 -> fpc=bfc00380.
REQ-037 Redirect while inst_req is held without addr_ok for 3 cycles -> inst_addr unchanged until addr_ok; that response is dropped.
REQ-038 fpc=fffffffc with FETCH_BYTES=4 -> next address 00000000.
